exc_commit_ctrl: RTL and testbench

//  Sequencer that commits a MEM-stage exception or ERET decided by the combinational exception unit.
//  - Waits for outstanding data-bus transactions to drain.
//  - Writes CP0 (EPC, Cause.ExcCode, BadVAddr, Status.EXL), flushes the pipeline, then redirects the PC.
//  - Sits between the exception unit, the CP0 register file, the hazard unit and the fetch PC mux.

---
 rtl/exc_pkg.sv | 22 ++
 rtl/exc_drain_timer.sv | 26 ++
 rtl/exc_commit_ctrl.sv | 124 ++++++++++++
 tb/tb_exc_commit_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/exc_pkg.sv
// rtl/exc_pkg.sv - shared state type, ExcCode values and vector for the exception commit sequencer
package exc_pkg;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DRAIN    = 2'd1,
    S_COMMIT   = 2'd2,
    S_REDIRECT = 2'd3
  } exc_state_t;

  localparam logic [4:0] INT  = 5'h00;
  localparam logic [4:0] ADEL = 5'h04;
  localparam logic [4:0] ADES = 5'h05;
  localparam logic [4:0] SYS  = 5'h08;
  localparam logic [4:0] BP   = 5'h09;
  localparam logic [4:0] RI   = 5'h0A;
  localparam logic [4:0] OV   = 5'h0C;
  localparam logic [4:0] TR   = 5'h0D;

  localparam logic [31:0] EXC_VEC_DEF = 32'hBFC0_0380;

endpackage

// File: rtl/exc_drain_timer.sv
// rtl/exc_drain_timer.sv - bounded cycle counter used to cap the bus-drain wait
module exc_drain_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned W = $clog2(TIMEOUT + 1);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      cnt_q <= '0;
    end else if (en_i && !expired_o) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expired_o = (cnt_q == W'(TIMEOUT - 1));

endmodule

// File: rtl/exc_commit_ctrl.sv
// rtl/exc_commit_ctrl.sv - drains the data bus, commits an exception/ERET to CP0, flushes and redirects the PC
// Optional EXC_BD_EN: delay-slot faults report EPC = pc - 4 and set Cause.BD.
module exc_commit_ctrl
  import exc_pkg::*;
#(
  parameter logic [31:0] EXC_VEC       = EXC_VEC_DEF,
  parameter int unsigned DRAIN_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exc_valid,
  input  logic        exc_is_eret,
  input  logic [4:0]  exc_code,
  input  logic [31:0] exc_pc,
  input  logic        exc_badv_vld,
  input  logic [31:0] exc_badvaddr,
  input  logic        exc_in_bd,
  input  logic [31:0] cp0_epc,
  input  logic        mem_busy,
  output logic        stall_req,
  output logic        flush,
  output logic        cp0_exc_we,
  output logic [31:0] cp0_epc_o,
  output logic [4:0]  cp0_exccode_o,
  output logic        cp0_bd_o,
  output logic        cp0_badv_we,
  output logic [31:0] cp0_badv_o,
  output logic        cp0_exl_clr,
  output logic        pc_redir_vld,
  output logic [31:0] pc_redir,
  output logic        drain_to
);

  exc_state_t  state_q;
  logic        eret_q;
  logic [4:0]  code_q;
  logic [31:0] pc_q;
  logic        badv_vld_q;
  logic [31:0] badv_q;
  logic        in_bd_q;
  logic [31:0] target_q;
  logic        drain_to_q;
  logic        expired;

  exc_drain_timer #(
    .TIMEOUT(DRAIN_TIMEOUT)
  ) u_drain_timer (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (state_q != S_DRAIN),
    .en_i     (state_q == S_DRAIN),
    .expired_o(expired)
  );

`ifdef EXC_BD_EN
  logic in_bd_d;
  assign in_bd_d = exc_in_bd;
`else
  logic in_bd_d;
  logic unused_in_bd;
  assign in_bd_d      = 1'b0;
  assign unused_in_bd = exc_in_bd;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      eret_q     <= 1'b0;
      code_q     <= '0;
      pc_q       <= '0;
      badv_vld_q <= 1'b0;
      badv_q     <= '0;
      in_bd_q    <= 1'b0;
      target_q   <= '0;
      drain_to_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (exc_valid) begin
            eret_q     <= exc_is_eret;
            code_q     <= exc_code;
            pc_q       <= exc_pc;
            badv_vld_q <= exc_badv_vld;
            badv_q     <= exc_badvaddr;
            in_bd_q    <= in_bd_d;
            state_q    <= mem_busy ? S_DRAIN : S_COMMIT;
          end
        end
        S_DRAIN: begin
          // A bus that frees up on the last allowed cycle is a clean drain, not a timeout.
          if (!mem_busy) begin
            state_q <= S_COMMIT;
          end else if (expired) begin
            state_q    <= S_COMMIT;
            drain_to_q <= 1'b1;
          end
        end
        S_COMMIT: begin
          target_q <= eret_q ? cp0_epc : EXC_VEC;
          state_q  <= S_REDIRECT;
        end
        S_REDIRECT: state_q <= S_IDLE;
        default:    state_q <= S_IDLE;
      endcase
    end
  end

  logic in_commit;
  assign in_commit = (state_q == S_COMMIT);

  assign stall_req     = (state_q != S_IDLE);
  assign flush         = in_commit;
  assign cp0_exc_we    = in_commit && !eret_q;
  assign cp0_exl_clr   = in_commit && eret_q;
  assign cp0_exccode_o = cp0_exc_we ? code_q : 5'd0;
  assign cp0_bd_o      = cp0_exc_we && in_bd_q;
  assign cp0_epc_o     = cp0_exc_we ? (in_bd_q ? pc_q - 32'd4 : pc_q) : 32'd0;
  assign cp0_badv_we   = cp0_exc_we && badv_vld_q;
  assign cp0_badv_o    = cp0_badv_we ? badv_q : 32'd0;
  assign pc_redir_vld  = (state_q == S_REDIRECT);
  assign pc_redir      = pc_redir_vld ? target_q : 32'd0;
  assign drain_to      = drain_to_q;

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// tb/tb_exc_commit_ctrl.sv - scoreboard bench for exc_commit_ctrl with a cycle-level reference model
module tb_exc_commit_ctrl;
  import exc_pkg::*;

  localparam int TO = 16;
  localparam logic [31:0] VEC = 32'hBFC0_0380;

  logic        clk = 1'b0;
  logic        rst;
  logic        exc_valid, exc_is_eret, exc_badv_vld, exc_in_bd, mem_busy;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc, exc_badvaddr, cp0_epc;
  logic        stall_req, flush, cp0_exc_we, cp0_bd_o, cp0_badv_we, cp0_exl_clr, pc_redir_vld, drain_to;
  logic [31:0] cp0_epc_o, cp0_badv_o, pc_redir;
  logic [4:0]  cp0_exccode_o;

  exc_commit_ctrl #(.EXC_VEC(VEC), .DRAIN_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .exc_valid(exc_valid), .exc_is_eret(exc_is_eret),
    .exc_code(exc_code), .exc_pc(exc_pc), .exc_badv_vld(exc_badv_vld),
    .exc_badvaddr(exc_badvaddr), .exc_in_bd(exc_in_bd), .cp0_epc(cp0_epc),
    .mem_busy(mem_busy), .stall_req(stall_req), .flush(flush), .cp0_exc_we(cp0_exc_we),
    .cp0_epc_o(cp0_epc_o), .cp0_exccode_o(cp0_exccode_o), .cp0_bd_o(cp0_bd_o),
    .cp0_badv_we(cp0_badv_we), .cp0_badv_o(cp0_badv_o), .cp0_exl_clr(cp0_exl_clr),
    .pc_redir_vld(pc_redir_vld), .pc_redir(pc_redir), .drain_to(drain_to)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    bit          eret;
    logic [4:0]  code;
    logic [31:0] epc;
    bit          bd;
    bit          badv_we;
    logic [31:0] badv;
    bit          dto;
    logic [31:0] tgt;
  } exp_t;

  exp_t commit_q[$];
  exp_t redir_q[$];

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  bit   dto_model = 0;
  bit   epc_vary = 1;
  logic [31:0] epc_base = 32'h0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] epc_hash(input int c);
    return (32'(c) * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction

  // CP0.EPC changes every cycle so the ERET target proves it was sampled in COMMIT.
  always begin
    @(posedge clk);
    #2;
    cp0_epc = epc_vary ? epc_hash(cyc) : epc_base;
  end

  task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (flush) begin
        if (commit_q.size() == 0) begin
          chk_eq("unexpected_commit", 32'(flush), 32'd0);
        end else begin
          e = commit_q.pop_front();
          chk_eq("commit_cycle", 32'(cyc), 32'(e.cyc));
          chk_eq("commit_stall", 32'(stall_req), 32'd1);
          chk_eq("commit_exc_we", 32'(cp0_exc_we), 32'(!e.eret));
          chk_eq("commit_exl_clr", 32'(cp0_exl_clr), 32'(e.eret));
          chk_eq("commit_drain_to", 32'(drain_to), 32'(e.dto));
          if (e.eret) begin
            chk_eq("eret_badv_we", 32'(cp0_badv_we), 32'd0);
          end else begin
            chk_eq("commit_epc", cp0_epc_o, e.epc);
            chk_eq("commit_exccode", 32'(cp0_exccode_o), 32'(e.code));
            chk_eq("commit_bd", 32'(cp0_bd_o), 32'(e.bd));
            chk_eq("commit_badv_we", 32'(cp0_badv_we), 32'(e.badv_we));
            if (e.badv_we) chk_eq("commit_badv", cp0_badv_o, e.badv);
          end
          redir_q.push_back(e);
        end
      end
      if (pc_redir_vld) begin
        if (redir_q.size() == 0) begin
          chk_eq("unexpected_redirect", 32'(pc_redir_vld), 32'd0);
        end else begin
          e = redir_q.pop_front();
          chk_eq("redir_cycle", 32'(cyc), 32'(e.cyc + 1));
          chk_eq("redir_target", pc_redir, e.tgt);
          chk_eq("redir_stall", 32'(stall_req), 32'd1);
        end
      end
    end
  end

  task automatic garbage_inputs();
    exc_valid    = 1'($urandom_range(0, 1));
    exc_is_eret  = 1'($urandom_range(0, 1));
    exc_code     = 5'($urandom);
    exc_pc       = $urandom;
    exc_badv_vld = 1'($urandom_range(0, 1));
    exc_badvaddr = $urandom;
    exc_in_bd    = 1'($urandom_range(0, 1));
  endtask

  // Called at posedge+1 of an idle cycle; returns at posedge+1 of the first idle cycle after the redirect.
  task automatic run_event(input bit eret, input logic [4:0] code, input logic [31:0] pc,
                           input bit bv, input logic [31:0] badv, input bit bd, input int nbusy);
    exp_t e;
    int   c0, off;
    chk_eq("idle_stall", 32'(stall_req), 32'd0);
    c0  = cyc;
    off = 1 + ((nbusy < TO) ? nbusy : TO);
    if (nbusy > TO) dto_model = 1;
    e.cyc  = c0 + off;
    e.eret = eret;
    e.code = code;
`ifdef EXC_BD_EN
    e.epc = bd ? pc - 32'd4 : pc;
    e.bd  = bd;
`else
    e.epc = pc;
    e.bd  = 0;
`endif
    e.badv_we = bv && !eret;
    e.badv    = badv;
    e.dto     = dto_model;
    e.tgt     = eret ? (epc_vary ? epc_hash(c0 + off) : epc_base) : VEC;
    commit_q.push_back(e);

    exc_valid = 1'b1; exc_is_eret = eret; exc_code = code; exc_pc = pc;
    exc_badv_vld = bv; exc_badvaddr = badv; exc_in_bd = bd;
    mem_busy = (nbusy > 0);
    for (int i = 1; i <= off + 1; i++) begin
      @(posedge clk); #1;
      garbage_inputs();
      mem_busy = (i < off) ? (i < nbusy) : 1'($urandom_range(0, 1));
    end
    @(posedge clk); #1;
    exc_valid = 1'b0;
    mem_busy  = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk_eq({tag, "_strobes"}, {24'd0, stall_req, flush, cp0_exc_we, cp0_bd_o, cp0_badv_we,
                               cp0_exl_clr, pc_redir_vld, drain_to}, 32'd0);
    chk_eq({tag, "_epc"}, cp0_epc_o, 32'd0);
    chk_eq({tag, "_badv"}, cp0_badv_o, 32'd0);
    chk_eq({tag, "_redir"}, pc_redir, 32'd0);
    chk_eq({tag, "_code"}, 32'(cp0_exccode_o), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  logic [4:0] codes [8];

  initial begin
    codes = '{INT, ADEL, ADES, SYS, BP, RI, OV, TR};
    rst = 1'b1; cp0_epc = 32'h0;
    exc_valid = 0; exc_is_eret = 0; exc_code = 0; exc_pc = 0;
    exc_badv_vld = 0; exc_badvaddr = 0; exc_in_bd = 0; mem_busy = 0;
    repeat (3) @(posedge clk);
    #1; rst = 1'b0;
    check_all_zero("reset");

    run_event(0, SYS, 32'hBFC0_1000, 0, 32'h0, 0, 0);
    run_event(0, ADEL, 32'h8000_0100, 1, 32'h0000_0003, 0, 3);
    epc_vary = 0; epc_base = 32'hBFC0_0200;
    run_event(1, 5'd0, 32'h8000_0200, 0, 32'h0, 0, 0);
    epc_vary = 1;
    run_event(0, OV, 32'h8000_0300, 0, 32'h0, 0, 16);
    run_event(0, TR, 32'h8000_0400, 0, 32'h0, 0, 40);
    run_event(0, BP, 32'h8000_0500, 0, 32'h0, 0, 0);
    chk_eq("drain_to_sticky", 32'(drain_to), 32'd1);

    // Event abandoned by a reset while draining.
    exc_valid = 1; exc_is_eret = 0; exc_code = SYS; exc_pc = 32'h8000_0600; mem_busy = 1;
    @(posedge clk); #1; exc_valid = 0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; mem_busy = 0; dto_model = 0;
    check_all_zero("mid_reset");
    run_event(0, SYS, 32'h8000_0700, 0, 32'h0, 0, 0);

    run_event(0, RI, 32'h8000_0004, 0, 32'h0, 1, 0);

    for (int n = 0; n < 60; n++) begin
      bit         er, bv;
      logic [4:0] cd;
      int         nb;
      er = ($urandom_range(0, 3) == 0);
      cd = codes[$urandom_range(0, 7)];
      bv = (cd == ADEL || cd == ADES) ? 1'($urandom_range(0, 1)) : 1'b0;
      nb = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 20)) : int'($urandom_range(0, 2));
      run_event(er, cd, $urandom, bv, $urandom, 1'($urandom_range(0, 1)), nb);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    repeat (3) @(posedge clk);
    #1;
    chk_eq("commit_q_drained", 32'(commit_q.size()), 32'd0);
    chk_eq("redir_q_drained", 32'(redir_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
